// File: rtl/digi_pkg.sv
// Shared definitions for the digi readout path: sequencer states and output word framing.
package digi_pkg;
  localparam int         OUT_W   = 16;
  localparam logic [1:0] HDR_TAG = 2'b10;
  localparam logic [3:0] TRL_TAG = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_REQ, S_WAIT, S_CAP, S_PUSH, S_TRL, S_NEXT, S_DONE
  } seq_state_t;
endpackage

// File: rtl/out_word_reg.sv
// Single-entry valid/ready holding register; a load always wins over a same-cycle accept.
module out_word_reg
  import digi_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [OUT_W-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] data
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/channel_readout_seq.sv
// Readout sequencer: walks enabled channels, reads how_many samples from each ring buffer
// and emits a header/data/trailer word stream over valid/ready.
module channel_readout_seq
  import digi_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int RB_SIZE = 10,
  parameter int WIDTH   = 12,
  parameter int RD_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [RB_SIZE-1:0]   how_many,
  input  logic [RB_SIZE-1:0]   start_addr,
  input  logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]       read_request,
  output logic [RB_SIZE-1:0]   read_address,
  output logic                 spi_done,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 pass_done
);
  seq_state_t         state, nxt;
  logic [NCH-1:0]     rem_q, req_onehot;
  logic [RB_SIZE-1:0] hm_q, sa_q, wcnt_q;
  logic [3:0]         ch_q, low_ch;
  logic [2:0]         lat_q;
  logic [WIDTH-1:0]   sample;
  logic [9:0]         hm10;
  logic               accept, ld;
  logic [OUT_W-1:0]   ld_word;

  assign accept    = out_valid && out_ready;
  assign hm10      = 10'(hm_q);
  assign busy      = (state != S_IDLE);
  assign pass_done = (state == S_DONE);
  assign spi_done  = (state == S_PUSH) && accept;

  // Lowest remaining channel, channel slice mux and request decode.
  always_comb begin
    low_ch     = '0;
    sample     = '0;
    req_onehot = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (rem_q[i]) low_ch = 4'(i);
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == 4'(i)) sample = ch_data[i*WIDTH +: WIDTH];
      req_onehot[i] = (ch_q == 4'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // Output words are loaded on entry to HDR/PUSH/TRL so each of those states
  // sees out_valid high from its first cycle.
  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    ld_word = '0;
    case (state)
      S_IDLE: if (start) nxt = S_NEXT;
      S_NEXT: begin
        if (|rem_q) begin
          nxt     = S_HDR;
          ld      = 1'b1;
          ld_word = {HDR_TAG, low_ch, hm10};
        end else begin
          nxt = S_DONE;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (hm_q == '0) begin
            nxt     = S_TRL;
            ld      = 1'b1;
            ld_word = {TRL_TAG, 2'b00, hm10};
          end else begin
            nxt = S_REQ;
          end
        end
      end
      S_REQ:  nxt = S_WAIT;
      S_WAIT: if (lat_q == 3'(RD_LAT - 1)) nxt = S_CAP;
      S_CAP: begin
        nxt     = S_PUSH;
        ld      = 1'b1;
        ld_word = {ch_q, 12'(sample)};
      end
      S_PUSH: begin
        if (accept) begin
          if (wcnt_q + 1'b1 == hm_q) begin
            nxt     = S_TRL;
            ld      = 1'b1;
            ld_word = {TRL_TAG, 2'b00, hm10};
          end else begin
            nxt = S_REQ;
          end
        end
      end
      S_TRL:  if (accept) nxt = S_NEXT;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q        <= '0;
      hm_q         <= '0;
      sa_q         <= '0;
      wcnt_q       <= '0;
      ch_q         <= '0;
      lat_q        <= '0;
      read_address <= '0;
      read_request <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rem_q <= ch_mask;
          hm_q  <= how_many;
          sa_q  <= start_addr;
        end
        S_NEXT: if (|rem_q) begin
          ch_q         <= low_ch;
          rem_q        <= rem_q & (rem_q - 1'b1);
          read_address <= sa_q;
          wcnt_q       <= '0;
        end
        S_CAP:  read_address <= read_address + 1'b1;
        S_PUSH: if (accept) wcnt_q <= wcnt_q + 1'b1;
        default: ;
      endcase
      lat_q <= (state == S_WAIT) ? lat_q + 3'd1 : 3'd0;
      if (nxt == S_REQ)                 read_request <= req_onehot;
      else if (state == S_TRL && accept) read_request <= '0;
    end
  end

  out_word_reg u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ld),
    .din     (ld_word),
    .ready   (out_ready),
    .valid   (out_valid),
    .data    (out_data)
  );
endmodule

// File: tb/tb_channel_readout_seq.sv
// Scoreboard bench for channel_readout_seq: expected words queued at start, checked on accept.
module tb_channel_readout_seq;
  localparam int NCH = 8, RB = 10, WIDTH = 12, RD_LAT = 2;

  logic                 clk = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [NCH-1:0]       ch_mask = '0, read_request;
  logic [RB-1:0]        how_many = '0, start_addr = '0, read_address;
  logic [NCH*WIDTH-1:0] ch_data;
  logic                 spi_done, out_valid, busy, pass_done;
  logic [15:0]          out_data;

  channel_readout_seq #(.NCH(NCH), .RB_SIZE(RB), .WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ch_mask(ch_mask), .how_many(how_many),
    .start_addr(start_addr), .ch_data(ch_data), .read_request(read_request),
    .read_address(read_address), .spi_done(spi_done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .pass_done(pass_done));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] word; logic is_data; logic [NCH-1:0] req; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, pd_cnt = 0, pd_cyc = 0, st_cyc = 0;
  logic rnd_ready = 1'b0;
  logic [RB-1:0] cur_sa = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_data(input int ch, input logic [RB-1:0] addr);
    return 12'(addr) + 12'((ch + 1) * 256);
  endfunction

  // Ring-buffer model: data for the shared address appears RD_LAT cycles later.
  logic [RB-1:0] apipe [RD_LAT];
  always @(posedge clk) begin
    apipe[0] <= read_address;
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NCH; i++) ch_data[i*WIDTH +: WIDTH] = model_data(i, apipe[RD_LAT-1]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  exp_t          mh;
  logic          macc, held_v = 1'b0;
  logic [15:0]   held_d;
  logic [NCH-1:0] prev_req = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      held_v   = 1'b0;
      prev_req = '0;
    end else begin
      macc = out_valid && out_ready;
      if (sb.size() > 0) mh = sb[0];
      else begin mh.word = '0; mh.is_data = 1'b0; mh.req = '0; end
      chk("rreq", read_request, mh.req);
      chk("spi_done", spi_done, macc && mh.is_data);
      if (read_request != '0 && prev_req == '0) chk("req_addr", read_address, cur_sa);
      if (read_request != '0 && prev_req != '0 && read_request != prev_req)
        chk("req_gap", read_request, prev_req);
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_d);
      end
      if (macc) begin
        if (sb.size() == 0) chk("word_unexpected", out_valid, 0);
        else begin
          chk("word", out_data, mh.word);
          void'(sb.pop_front());
        end
      end
      held_v   = out_valid && !out_ready;
      held_d   = out_data;
      prev_req = read_request;
      if (pass_done) begin pd_cnt++; pd_cyc = cyc; end
      if (start && !busy) st_cyc = cyc;
    end
  end

  task automatic push_exp(input logic [NCH-1:0] m, input logic [RB-1:0] hm, input logic [RB-1:0] sa);
    exp_t e;
    for (int c = 0; c < NCH; c++) if (m[c]) begin
      e.word = {2'b10, 4'(c), 10'(hm)}; e.is_data = 1'b0; e.req = '0;
      sb.push_back(e);
      for (int k = 0; k < int'(hm); k++) begin
        e.word = {4'(c), model_data(c, RB'(sa + k))}; e.is_data = 1'b1;
        e.req = NCH'(1) << c;
        sb.push_back(e);
      end
      e.word = {4'hF, 2'b00, 10'(hm)}; e.is_data = 1'b0;
      e.req = (hm != 0) ? NCH'(1) << c : '0;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m, input logic [RB-1:0] hm, input logic [RB-1:0] sa);
    cur_sa = sa;
    @(posedge clk); #1;
    start = 1'b1; ch_mask = m; how_many = hm; start_addr = sa;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_pass(input logic [NCH-1:0] m, input logic [RB-1:0] hm, input logic [RB-1:0] sa,
                          input logic rnd, input logic dbl);
    int n, pd0, exp_lat;
    rnd_ready = rnd;
    pd0 = pd_cnt;
    exp_lat = 2;
    for (int c = 0; c < NCH; c++) if (m[c]) exp_lat += 3 + int'(hm) * (RD_LAT + 3);
    push_exp(m, hm, sa);
    pulse_start(m, hm, sa);
    n = 0;
    while (pd_cnt == pd0 && n < 5000) begin
      @(posedge clk); #1 n++;
      if (dbl && n == 6) begin start = 1'b1; ch_mask = '1; how_many = 7; start_addr = 0; end
      else start = 1'b0;
    end
    repeat (3) @(posedge clk);
    chk("pass_done_cnt", pd_cnt - pd0, 1);
    chk("sb_drain", sb.size(), 0);
    if (!rnd) chk("pass_lat", pd_cyc - st_cyc, exp_lat);
    rnd_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rreq", read_request, 0);
    chk("rst_raddr", read_address, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_spi", spi_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pd", pass_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    #1 reset_n = 1'b1;

    run_pass(8'h01, 10'd3, 10'd5, 1'b0, 1'b0);      // single channel, stream 8003 0105..F003
    run_pass(8'h84, 10'd1, 10'd32, 1'b0, 1'b0);     // ch2 then ch7
    run_pass(8'h08, 10'd4, 10'd1022, 1'b0, 1'b0);   // address wrap
    run_pass(8'hA5, 10'd5, 10'd100, 1'b1, 1'b0);    // random backpressure
    run_pass(8'h12, 10'd0, 10'd9, 1'b0, 1'b0);      // header+trailer only
    run_pass(8'h80, 10'd2, 10'd1023, 1'b1, 1'b0);

    // Reset in the middle of a data word.
    push_exp(8'h01, 10'd3, 10'd40);
    pulse_start(8'h01, 10'd3, 10'd40);
    n = 0;
    while (!(out_valid && out_data[15:12] == 4'h0) && n < 200) begin @(negedge clk); n++; end
    chk("push_reached", n < 200, 1);
    pd0 = pd_cnt;
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs();
    sb.delete();
    repeat (4) @(posedge clk);
    chk("rst_no_pass_done", pd_cnt - pd0, 0);
    @(negedge clk); #1 reset_n = 1'b1;

    run_pass(8'h00, 10'd5, 10'd3, 1'b0, 1'b0);      // empty mask: pass_done 2 cycles after start
    run_pass(8'h41, 10'd2, 10'd7, 1'b0, 1'b1);      // second start while busy is ignored

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/channel_readout_seq.md
Name: channel_readout_seq

Overview:
Readout sequencer downstream of the per-channel capture/ring-buffer stage in digi_many. After a capture it walks the enabled channels in order. For each channel it:
- asserts that channel's read request,
- steps the shared read address through how_many words,
- captures each returned sample,
- emits a framed 16-bit word stream (header, data, trailer) over a valid/ready interface towards the SPI output logic.

Parameters:
NCH, 8, number of channels; legal range 1..16.
RB_SIZE, 10, ring-buffer address width; legal range up to 10.
WIDTH, 12, sample width; legal range up to 12.
RD_LAT, 2, clk cycles from read_address/read_request valid to ch_data valid; legal range 1..7.

Ports:
clk  in  1  system clock (CK50 domain); all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse that begins a readout pass.
ch_mask  in  NCH  channel enable bitmap, sampled at start.
how_many  in  RB_SIZE  words per channel, sampled at start.
start_addr  in  RB_SIZE  first ring-buffer address, sampled at start.
ch_data  in  NCH*WIDTH  concatenated channel data_out buses; channel i occupies bits [i*WIDTH +: WIDTH].
read_request  out  NCH  one-hot request to the channel being read.
read_address  out  RB_SIZE  shared ring-buffer read address.
spi_done  out  1  one-cycle pulse per accepted data word.
out_data  out  16  framed output word.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream accepts the word when out_valid && out_ready.
busy  out  1  high from the cycle after start until DONE.
pass_done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset values: read_request=0, read_address=0, out_valid=0, out_data=0, spi_done=0, busy=0, pass_done=0. All internal counters are 0 and the FSM is in IDLE.
- Asynchronous reset_n assertion aborts any pass at once. Any word in flight is dropped and no pass_done is produced.
- States and transitions:
  - IDLE: waits for start.
  - HDR: emits the header word for the current channel.
  - REQ: drives read_request and read_address.
  - WAIT: counts RD_LAT cycles.
  - CAP: registers the selected WIDTH slice of ch_data.
  - PUSH: emits the data word.
  - TRL: emits the trailer word.
  - NEXT: selects the next enabled channel, or goes to DONE.
  - DONE: pulses pass_done, then returns to IDLE.
- On start in IDLE: latch ch_mask, how_many and start_addr, then search for the lowest set mask bit.
  - If the mask is all-zero, go directly to DONE: pass_done pulses 2 cycles after start and no words are emitted.
- start is ignored while busy=1.
- Output handshake:
  - out_valid and out_data are registered and held stable until out_ready is seen high.
  - The FSM does not advance out of HDR, PUSH or TRL until the handshake completes.
  - out_ready held low stalls the FSM indefinitely.
- Word formats:
  - Header: {2'b10, ch[3:0], how_many zero-extended to 10 bits}.
  - Data: {ch[3:0], sample zero-extended to 12 bits}.
  - Trailer: {4'hF, 2'b00, count of data words sent, 10 bits}.
- Addressing:
  - read_address starts at start_addr for every channel.
  - It increments by 1 after each CAP and wraps modulo 2^RB_SIZE, so 1023 is followed by 0 when RB_SIZE=10.
- read_request[ch] stays high from the first REQ of a channel until its trailer is accepted. It drops for at least 1 cycle between channels.
- spi_done pulses in the cycle a data word is accepted. Header and trailer acceptance do not produce a pulse.
- how_many=0: the channel emits header then trailer with count 0, and no read_request is asserted.
- Per-channel cycle count with out_ready tied high: 1 (HDR) + how_many*(RD_LAT+3) + 1 (TRL) + 1 (NEXT).
- Channels are visited in ascending index order; masked channels are skipped with no words emitted.

Decomposition:
- Shared package (digi_pkg):
  - FSM state encodings.
  - Word-tag constants HDR_TAG=2'b10 and TRL_TAG=4'hF.
  - OUT_W=16.
- One natural sub-module, out_word_reg: a single-entry valid/ready holding register for out_data/out_valid.
- Channel selection (priority search of the remaining mask) stays inline.

Test Plan:
1. NCH=8, ch_mask=8'h01, how_many=3, start_addr=5, ch_data ch0 = address+12'h100, out_ready=1 -> expected stream 16'h8003, 16'h0105, 16'h0106, 16'h0107, 16'hF003. read_address steps 5,6,7. spi_done pulses 3 times. pass_done pulses once.
2. ch_mask=8'h84, how_many=1 -> header 16'h8801 for ch2, then header 16'h9C01 for ch7. Each data word carries channel 2 or 7 respectively. read_request takes values 8'h04 and 8'h80 with a gap of at least 1 cycle between them.
3. start_addr=1022, how_many=4 -> read_address sequence 1022, 1023, 0, 1. Trailer count is 4.
4. out_ready toggled 1/0 at random -> out_data stays stable while out_valid=1 and out_ready=0. No word is lost or duplicated. Word count equals 2 + how_many per enabled channel.
5. Apply reset_n=0 mid-PUSH, then start with ch_mask=0 -> outputs return to reset values asynchronously with no pass_done. Later, start with ch_mask=0 gives pass_done 2 cycles after start and zero words.
6. Pulse start again while busy -> ignored. The pass completes unchanged, and exactly one pass_done is produced.
